// File: rtl/phj_pkg.sv
// Shared definitions for the partitioned hash join phase controller.
//   phj_ctrl_state_t : controller phase encoding
//   PHJ_LANES        : lane count of the join datapath
//   popcount8        : number of set bits in an 8-lane mask (0..8)
package phj_pkg;

  localparam int unsigned PHJ_LANES = 8;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    BUILD,
    DRAIN_B,
    PROBE,
    DRAIN_P,
    DONE
  } phj_ctrl_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/phj_sat_counter.sv
// Saturating accumulator used for the build, probe and result tallies.
//   clk     : clock
//   reset   : synchronous active-high reset (count -> 0)
//   i_clr   : synchronous clear, wins over i_inc
//   i_inc   : amount to add this cycle (0..8)
//   o_count : current count, sticks at all-ones instead of wrapping
module phj_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic [3:0]       i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W:0]   w_sum;

  // One extra bit catches the carry out that signals overflow.
  assign w_sum = {1'b0, r_count} + (CNT_W + 1)'(i_inc);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (w_sum[CNT_W]) begin
      r_count <= '1;
    end else begin
      r_count <= w_sum[CNT_W-1:0];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/phj_join_controller.sv
// Phase sequencer for the 8-lane partitioned hash join. Gates build/probe
// valid/ready so tuples only enter in their phase, waits for hash table
// init, detects build and probe drain, raises start_probing and counts
// accepted build tuples, probe tuples and result beats.
//   clk, reset                : clock, synchronous active-high reset
//   cmd_start/busy/done       : host control (start join or re-probe)
//   build_src_* / probe_src_* : tuple source handshakes and done levels
//   phj_build_in_* / phj_probe_in_* : gated handshakes to the join
//   phj_ht_initialized        : hash tables ready
//   phj_ht_out_valid          : per-lane join result valid
//   phj_start_probing         : sticky probe-phase flag to the join
//   build/probe/result_count  : saturating tallies
module phj_join_controller
  import phj_pkg::*;
#(
  parameter int unsigned LANES        = 8,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned DRAIN_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_start,
  output logic             cmd_busy,
  output logic             cmd_done,
  input  logic [LANES-1:0] build_src_valid,
  output logic [LANES-1:0] build_src_ready,
  input  logic             build_src_done,
  input  logic [LANES-1:0] probe_src_valid,
  output logic [LANES-1:0] probe_src_ready,
  input  logic             probe_src_done,
  output logic [LANES-1:0] phj_build_in_valid,
  input  logic [LANES-1:0] phj_build_in_ready,
  output logic [LANES-1:0] phj_probe_in_valid,
  input  logic [LANES-1:0] phj_probe_in_ready,
  input  logic             phj_ht_initialized,
  input  logic [LANES-1:0] phj_ht_out_valid,
  output logic             phj_start_probing,
  output logic [CNT_W-1:0] build_count,
  output logic [CNT_W-1:0] probe_count,
  output logic [CNT_W-1:0] result_count
);

  localparam int unsigned QW = $clog2(DRAIN_CYCLES + 1);

  phj_ctrl_state_t r_state, w_state_d;
  logic [QW-1:0]   r_quiet, w_quiet_d;
  logic            r_start_probing;

  logic w_build_en, w_probe_en;
  logic w_activity, w_quiet_full;
  logic w_clr_all, w_clr_probe;
  logic [3:0] w_build_inc, w_probe_inc, w_result_inc;

  assign w_build_en = (r_state == BUILD);
  assign w_probe_en = (r_state == PROBE);

  assign phj_build_in_valid = build_src_valid & {LANES{w_build_en}};
  assign build_src_ready    = phj_build_in_ready & {LANES{w_build_en}};
  assign phj_probe_in_valid = probe_src_valid & {LANES{w_probe_en}};
  assign probe_src_ready    = phj_probe_in_ready & {LANES{w_probe_en}};

  assign cmd_busy          = (r_state != IDLE) && (r_state != DONE);
  assign cmd_done          = (r_state == DONE);
  assign phj_start_probing = r_start_probing;

  // Drain activity: backpressure from the build side, results still emerging.
  assign w_activity = ((r_state == DRAIN_B) && !(&phj_build_in_ready)) ||
                      ((r_state == DRAIN_P) && (|phj_ht_out_valid));
  assign w_quiet_full = (r_quiet == QW'(DRAIN_CYCLES));

  // Held at zero outside the drain states, so each drain starts from zero.
  always_comb begin
    w_quiet_d = '0;
    if (((r_state == DRAIN_B) || (r_state == DRAIN_P)) && !w_activity) begin
      w_quiet_d = w_quiet_full ? r_quiet : r_quiet + QW'(1);
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_clr_all   = 1'b0;
    w_clr_probe = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cmd_start) begin
          w_state_d = INIT;
          w_clr_all = 1'b1;
        end
      end
      INIT: begin
        if (phj_ht_initialized) w_state_d = BUILD;
      end
      BUILD: begin
        if (build_src_done && (build_src_valid == '0)) w_state_d = DRAIN_B;
      end
      DRAIN_B: begin
        if (w_quiet_full && phj_ht_initialized) w_state_d = PROBE;
      end
      PROBE: begin
        if (probe_src_done && (probe_src_valid == '0)) w_state_d = DRAIN_P;
      end
      DRAIN_P: begin
        if (w_quiet_full) w_state_d = DONE;
      end
      DONE: begin
        if (cmd_start) begin
          w_state_d   = PROBE;
          w_clr_probe = 1'b1;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_quiet         <= '0;
      r_start_probing <= 1'b0;
    end else begin
      r_state         <= w_state_d;
      r_quiet         <= w_quiet_d;
      // Sticky: set on entry to PROBE so it is high in the first PROBE cycle.
      r_start_probing <= r_start_probing || (w_state_d == PROBE);
    end
  end

  assign w_build_inc  = popcount8(phj_build_in_valid & build_src_ready);
  assign w_probe_inc  = popcount8(phj_probe_in_valid & probe_src_ready);
  assign w_result_inc = ((r_state == PROBE) || (r_state == DRAIN_P)) ?
                        popcount8(phj_ht_out_valid) : 4'd0;

  phj_sat_counter #(.CNT_W(CNT_W)) u_build_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr_all),
    .i_inc   (w_build_inc),
    .o_count (build_count)
  );

  phj_sat_counter #(.CNT_W(CNT_W)) u_probe_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr_all || w_clr_probe),
    .i_inc   (w_probe_inc),
    .o_count (probe_count)
  );

  phj_sat_counter #(.CNT_W(CNT_W)) u_result_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_clr_all || w_clr_probe),
    .i_inc   (w_result_inc),
    .o_count (result_count)
  );

endmodule

// File: doc/phj_join_controller.md
Name: phj_join_controller

Overview:
Phase sequencer wrapped around the 8-lane partitioned hash join (murmur hashing, DD8 distribution, 8 hash tables). It gates the build and probe streams so tuples enter only in the correct phase, waits for table initialisation, and detects build and probe drain. It raises start_probing and counts accepted build tuples, probe tuples and join results. It sits between the tuple sources or DMA and the join datapath and reports busy/done to host control.

Parameters:
LANES, 8, number of parallel lanes; fixed at 8 to match the join datapath
CNT_W, 32, width of the build, probe and result counters
DRAIN_CYCLES, 16, consecutive quiet cycles that declare the pipeline drained; must be at least 2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_start  in  1  pulse; starts a join from IDLE, or a re-probe from DONE
cmd_busy  out  1  high in every state except IDLE and DONE
cmd_done  out  1  high while in DONE
build_src_valid  in  8  per-lane valid from the build source
build_src_ready  out  8  per-lane ready to the build source
build_src_done  in  1  level; build source has no further tuples
probe_src_valid  in  8  per-lane valid from the probe source
probe_src_ready  out  8  per-lane ready to the probe source
probe_src_done  in  1  level; probe source has no further tuples
phj_build_in_valid  out  8  gated valid into the join build port
phj_build_in_ready  in  8  join build_in_ready
phj_probe_in_valid  out  8  gated valid into the join probe port
phj_probe_in_ready  in  8  join probe_in_ready
phj_ht_initialized  in  1  all hash tables ready
phj_ht_out_valid  in  8  join per-lane result valid
phj_start_probing  out  1  drives the join start_probing
build_count  out  CNT_W  accepted build tuples
probe_count  out  CNT_W  accepted probe tuples
result_count  out  CNT_W  result beats observed

Behaviour:
- One clock; reset is synchronous and active-high.
- On reset: state IDLE; all counters 0; phj_start_probing 0; cmd_busy 0; cmd_done 0; all gated valids and readies 0.
- Data buses are not routed through this block. It gates valid and ready only.
- Gating is combinational, with no added latency:
  - build_en = (state == BUILD); probe_en = (state == PROBE).
  - phj_build_in_valid = build_src_valid & {8{build_en}}; build_src_ready = phj_build_in_ready & {8{build_en}}.
  - Probe gating is identical, using probe_en.
- A lane fires when its gated valid and ready are both high in the same cycle.
- build_count += popcount(fired build lanes) each cycle; probe_count likewise for probe lanes.
- result_count += popcount(phj_ht_out_valid) in PROBE and DRAIN_P.
- All counters saturate at 2^CNT_W-1 and never wrap.
- quiet_cnt: cleared on entry to each DRAIN state and whenever any monitored activity occurs; otherwise increments, saturating at DRAIN_CYCLES.
- States:
  - IDLE: on cmd_start, go to INIT and clear all counters.
  - INIT: when phj_ht_initialized = 1, go to BUILD.
  - BUILD: when build_src_done = 1 and build_src_valid == 0, go to DRAIN_B.
  - DRAIN_B: activity is any phj_build_in_ready bit low. When quiet_cnt == DRAIN_CYCLES and phj_ht_initialized = 1, go to PROBE.
  - PROBE: phj_start_probing is registered high from the first PROBE cycle onward. When probe_src_done = 1 and probe_src_valid == 0, go to DRAIN_P.
  - DRAIN_P: activity is any phj_ht_out_valid bit high. When quiet_cnt == DRAIN_CYCLES, go to DONE.
  - DONE: cmd_start clears probe_count and result_count and goes to PROBE (re-probe against the same tables). build_count is held.
- phj_start_probing stays high from the first PROBE cycle until reset; a re-probe does not drop it.
- cmd_start outside IDLE and DONE is ignored.
- If a *_src_done level rises in the same cycle as a final firing, that beat is counted and the exit happens in the next cycle that has no valid.
- Source valids presented in the wrong phase see ready = 0 and are held; they are not lost or counted.
- Reset mid-operation returns to IDLE next cycle. The datapath must be reset in the same cycle.

Decomposition:
- Shared package phj_pkg holds:
  - phj_ctrl_state_t enum: IDLE, INIT, BUILD, DRAIN_B, PROBE, DRAIN_P, DONE.
  - PHJ_LANES = 8.
  - popcount8 function, returning 4 bits.
- One sub-module, phj_sat_counter (CNT_W-wide saturating accumulator with clear and a 4-bit increment), instantiated three times.

Test Plan:
- Basic join: hold phj_ht_initialized low 5 cycles after cmd_start, push 64 build tuples (8 beats, all lanes), raise build_src_done, push 16 probe tuples, return 10 result beats. Expect: INIT held 5 cycles; build_count = 64; phj_start_probing rises only after DRAIN_CYCLES quiet cycles; probe_count = 16; result_count = 10; cmd_done = 1.
- Phase gating: drive probe_src_valid = 8'hFF during BUILD. Expect probe_src_ready = 0, phj_probe_in_valid = 0, probe_count = 0 until PROBE, then all 8 accepted in the first PROBE cycle.
- Backpressure and drain: hold phj_build_in_ready = 8'h0F for 3 cycles after build_src_done. Expect DRAIN_B to restart quiet_cnt and leave exactly DRAIN_CYCLES cycles after the last low ready; build_count counts only lanes 0-3 during those cycles.
- Saturation: with CNT_W = 4, accept 20 build tuples. Expect build_count = 15, with no wrap.
- Re-probe: in DONE, pulse cmd_start and run 8 probes with 3 results. Expect build_count unchanged, probe_count = 8, result_count = 3, phj_start_probing stays 1.
- Reset mid-BUILD: assert reset for 1 cycle. Expect IDLE, counters 0, phj_start_probing 0, and all gated valid and ready outputs 0 on the following cycle.
